pipe_gap_gen: RTL and testbench

Consumer end of the free-running 8-bit random stream. Each cycle it samples the random byte and turns it into playable pipe-gap vertical positions. Candidates that are out of range or that jump too far from the previous gap are rejected; after a bounded number of retries a clamped value is forced instead. Accepted gaps are buffered in a small show-ahead FIFO, which the pipe/scroll logic pops with a valid/ready handshake whenever it spawns a new pipe.

---
 rtl/pipe_gap_gen_pkg.sv | 24 ++
 rtl/pipe_gap_gen_if.sv | 36 +++
 rtl/pipe_gap_gen_gap_fifo.sv | 61 ++++++
 rtl/pipe_gap_gen.sv | 131 +++++++++++++
 tb/tb_pipe_gap_gen.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pipe_gap_gen_pkg.sv
// Screen geometry shared by the gap generator, the pipe renderer and the
// collision logic, plus the sampler state encoding.
package pipe_gap_gen_pkg;

    // Width of a screen row coordinate.
    localparam int ROW_W = 9;

    // Default gap geometry: lowest legal row and number of legal positions.
    localparam int GAP_MIN_DEFAULT  = 40;
    localparam int GAP_SPAN_DEFAULT = 160;

    // Sampler state mirrors FIFO fullness: SAMPLE while there is room,
    // HOLD while every slot is occupied.
    typedef enum logic {
        ST_SAMPLE = 1'b0,
        ST_HOLD   = 1'b1
    } sampler_state_t;

    // Unsigned distance between two positions, never wraps.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pipe_gap_gen_if.sv
// Gap stream towards the pipe/scroll logic.
//
// Handshake: gap_y is meaningful whenever gap_valid is high and stays stable
// until taken; an entry is consumed on each rising clock edge where both
// gap_valid and gap_ready are high. gap_ready while gap_valid is low is ignored.
// level and state are observation signals (FIFO occupancy and sampler state).
interface pipe_gap_gen_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [pipe_gap_gen_pkg::ROW_W-1:0] gap_y;
    logic                               gap_valid;
    logic                               gap_ready;
    logic [LVL_W-1:0]                   level;
    pipe_gap_gen_pkg::sampler_state_t   state;

    // Producer side: the gap generator.
    modport master (
        output gap_y,
        output gap_valid,
        output level,
        output state,
        input  gap_ready
    );

    // Consumer side: the pipe/scroll logic (or a bench).
    modport slave (
        input  gap_y,
        input  gap_valid,
        input  level,
        input  state,
        output gap_ready
    );

endinterface

// File: rtl/pipe_gap_gen_gap_fifo.sv
// Generic show-ahead FIFO. The head entry is presented combinationally from
// storage and reads zero when the FIFO is empty. Pushes into a full FIFO and
// pops from an empty one are ignored.
module gap_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && (count != FULL_LVL);
    assign do_pop  = pop && (count != '0);

    // Storage array; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = (count != '0) ? mem[rd_ptr] : '0;
    assign level = count;

endmodule

// File: rtl/pipe_gap_gen.sv
// Turns the free-running random byte into playable pipe-gap rows. A candidate
// is accepted when it is in range and close enough to the previous gap; after
// MAX_TRIES consecutive rejects a folded and clamped value is forced instead.
// Accepted rows are queued in a show-ahead FIFO for the pipe spawner.
module pipe_gap_gen
    import pipe_gap_gen_pkg::*;
#(
    parameter int GAP_MIN   = GAP_MIN_DEFAULT,
    parameter int GAP_SPAN  = GAP_SPAN_DEFAULT,
    parameter int MAX_STEP  = 48,
    parameter int MAX_TRIES = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rnd_in,
    pipe_gap_gen_if.master       gap
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
    localparam logic [9:0]       SPAN      = 10'(GAP_SPAN);
    localparam logic [9:0]       SPAN_TOP  = 10'(GAP_SPAN - 1);
    localparam logic [9:0]       STEP      = 10'(MAX_STEP);
    localparam logic [ROW_W-1:0] ROW_BASE  = ROW_W'(GAP_MIN);
    localparam logic [7:0]       PREV_INIT = 8'(GAP_SPAN / 2);

    sampler_state_t     state_q;
    sampler_state_t     state_d;
    logic [TRY_W-1:0]   tries_q;
    logic [TRY_W-1:0]   tries_d;
    logic [7:0]         prev_q;
    logic [7:0]         prev_d;

    logic               push;
    logic [7:0]         push_data;
    logic               pop;
    logic [7:0]         head;
    logic [LVL_W-1:0]   level;
    logic [LVL_W-1:0]   level_next;

    // Candidate arithmetic, all in 10 bits so nothing wraps.
    logic [9:0]         cand;
    logic [9:0]         prev_w;
    logic [9:0]         folded;
    logic [9:0]         lo_bound;
    logic [9:0]         hi_raw;
    logic [9:0]         hi_bound;
    logic [9:0]         clamped;
    logic               accept;

    assign cand     = {2'b00, rnd_in};
    assign prev_w   = {2'b00, prev_q};
    assign accept   = (cand < SPAN) && (abs_diff(cand, prev_w) <= STEP);
    assign folded   = (cand >= SPAN) ? (cand - SPAN) : cand;
    assign lo_bound = (prev_w > STEP) ? (prev_w - STEP) : 10'd0;
    assign hi_raw   = prev_w + STEP;
    assign hi_bound = (hi_raw > SPAN_TOP) ? SPAN_TOP : hi_raw;
    assign clamped  = (folded < lo_bound) ? lo_bound :
                      (folded > hi_bound) ? hi_bound : folded;

    assign pop = gap.gap_valid && gap.gap_ready;

    // Sampler next state: accept, force after the last try, or count a reject.
    always_comb begin
        push       = 1'b0;
        push_data  = 8'd0;
        prev_d     = prev_q;
        tries_d    = tries_q;
        if (state_q == ST_SAMPLE) begin
            if (accept) begin
                push      = 1'b1;
                push_data = 8'(cand);
                prev_d    = 8'(cand);
                tries_d   = '0;
            end else if (tries_q == LAST_TRY) begin
                push      = 1'b1;
                push_data = 8'(clamped);
                prev_d    = 8'(clamped);
                tries_d   = '0;
            end else begin
                tries_d   = tries_q + TRY_W'(1);
            end
        end
    end

    // Fullness tracking: the state for the next cycle is whether the FIFO ends this cycle full.
    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
        state_d = (level_next == FULL_LVL) ? ST_HOLD : ST_SAMPLE;
    end

    // Sampler registers: state, retry counter and last accepted position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SAMPLE;
            tries_q <= '0;
            prev_q  <= PREV_INIT;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            prev_q  <= prev_d;
        end
    end

    gap_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .level     (level)
    );

    assign gap.gap_valid = (level != '0);
    assign gap.gap_y     = gap.gap_valid ? (ROW_BASE + {1'b0, head}) : '0;
    assign gap.level     = level;
    assign gap.state     = state_q;

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Directed bench for pipe_gap_gen with default parameters.
module tb_pipe_gap_gen;
    import pipe_gap_gen_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] rnd_in;
    int         total;
    int         bad;

    pipe_gap_gen_if #(.DEPTH(4)) gap_bus ();

    pipe_gap_gen dut (
        .clk    (clk),
        .rst    (rst),
        .rnd_in (rnd_in),
        .gap    (gap_bus.master)
    );

    // Clock: 10 time units, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, then settle 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse the asynchronous reset between edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rnd_in = 8'd0;
        gap_bus.gap_ready = 1'b0;

        // Reset values.
        #1;
        check("rst_level", 32'(gap_bus.level), 0);
        check("rst_valid", 32'(gap_bus.gap_valid), 0);
        check("rst_gap_y", 32'(gap_bus.gap_y), 0);
        check("rst_state", 32'(gap_bus.state), 32'(ST_SAMPLE));

        // 1: steady accept to full, then hold.
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rnd_in = 8'd100;
        tick(1);
        check("s1_level1", 32'(gap_bus.level), 1);
        check("s1_valid1", 32'(gap_bus.gap_valid), 1);
        check("s1_gap_y", 32'(gap_bus.gap_y), 140);
        tick(3);
        check("s1_level4", 32'(gap_bus.level), 4);
        check("s1_hold", 32'(gap_bus.state), 32'(ST_HOLD));
        tick(3);
        check("s1_level_hold", 32'(gap_bus.level), 4);
        check("s1_gap_y_hold", 32'(gap_bus.gap_y), 140);

        // 2: out of range, forced on the 8th try; retry counter restarts after it.
        do_reset();
        rnd_in = 8'd200;
        tick(7);
        check("s2_no_push", 32'(gap_bus.level), 0);
        tick(1);
        check("s2_forced_level", 32'(gap_bus.level), 1);
        check("s2_forced_gap_y", 32'(gap_bus.gap_y), 80);
        tick(7);
        check("s2_retry_restart", 32'(gap_bus.level), 1);
        tick(1);
        check("s2_second_force", 32'(gap_bus.level), 2);

        // 3: upper clamp to 128, then 150 accepted immediately.
        do_reset();
        rnd_in = 8'd150;
        tick(7);
        check("s3_no_push", 32'(gap_bus.level), 0);
        tick(1);
        check("s3_clamp_gap_y", 32'(gap_bus.gap_y), 168);
        tick(1);
        check("s3_accept_level", 32'(gap_bus.level), 2);
        check("s3_head_kept", 32'(gap_bus.gap_y), 168);
        gap_bus.gap_ready = 1'b1;
        tick(1);
        gap_bus.gap_ready = 1'b0;
        check("s3_pop_push_level", 32'(gap_bus.level), 2);
        check("s3_next_gap_y", 32'(gap_bus.gap_y), 190);

        // 4: lower clamp to 32; pops while empty are ignored.
        do_reset();
        rnd_in = 8'd10;
        gap_bus.gap_ready = 1'b1;
        tick(7);
        check("s4_no_push", 32'(gap_bus.level), 0);
        tick(1);
        gap_bus.gap_ready = 1'b0;
        check("s4_level", 32'(gap_bus.level), 1);
        check("s4_clamp_gap_y", 32'(gap_bus.gap_y), 72);

        // 5: pop at full, refill on the following edge.
        do_reset();
        rnd_in = 8'd100;
        tick(1);
        rnd_in = 8'd110;
        tick(1);
        rnd_in = 8'd120;
        tick(1);
        rnd_in = 8'd130;
        tick(1);
        check("s5_full", 32'(gap_bus.level), 4);
        check("s5_head", 32'(gap_bus.gap_y), 140);
        rnd_in = 8'd90;
        tick(2);
        check("s5_hold_level", 32'(gap_bus.level), 4);
        gap_bus.gap_ready = 1'b1;
        tick(1);
        gap_bus.gap_ready = 1'b0;
        check("s5_pop_level", 32'(gap_bus.level), 3);
        check("s5_pop_gap_y", 32'(gap_bus.gap_y), 150);
        check("s5_pop_state", 32'(gap_bus.state), 32'(ST_SAMPLE));
        tick(1);
        check("s5_refill_level", 32'(gap_bus.level), 4);
        check("s5_refill_gap_y", 32'(gap_bus.gap_y), 150);
        gap_bus.gap_ready = 1'b1;
        tick(3);
        gap_bus.gap_ready = 1'b0;
        check("s5_tail_gap_y", 32'(gap_bus.gap_y), 130);

        // 6: asynchronous reset mid-run, then first gap one edge after release.
        do_reset();
        rnd_in = 8'd100;
        tick(3);
        check("s6_level3", 32'(gap_bus.level), 3);
        rst = 1'b1;
        #1;
        check("s6_async_valid", 32'(gap_bus.gap_valid), 0);
        check("s6_async_level", 32'(gap_bus.level), 0);
        check("s6_async_gap_y", 32'(gap_bus.gap_y), 0);
        rst = 1'b0;
        tick(1);
        check("s6_first_gap_y", 32'(gap_bus.gap_y), 140);
        check("s6_first_level", 32'(gap_bus.level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
